pred_sched: RTL and testbench

Scheduler in front of the 2-bit saturating-counter branch predictor, which performs one operation per clock: an update when `result` is high, otherwise a prediction when `request` is high. Shares that single port between a fetch-side prediction requester and a backend resolution stream, and buffers resolved outcomes in a small FIFO. Enforces one-hot use of the predictor port, bounds fetch starvation, and tracks predictions still awaiting resolution.

---
 rtl/pred_sched_if.sv | 42 ++++
 rtl/pred_sched.sv | 139 +++++++++++++
 tb/tb_pred_sched.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pred_sched_if.sv
// pred_sched_if: bundle of the fetch, backend-resolution and predictor-port
// signals served by pred_sched.
//   slave  modport : the scheduler side (pred_sched).
//   master modport : the surrounding fetch/backend/predictor environment.
// Signals:
//   fe_req/fe_ready            fetch prediction request / grant
//   fe_pred_valid/fe_pred      registered prediction return
//   be_upd_valid/taken/ready   resolved-branch stream into the update queue
//   p_request/p_result/p_taken to the predictor; p_prediction from it
//   outstanding                unresolved prediction count
//   underflow                  sticky "update with nothing outstanding"
interface pred_sched_if #(
  parameter int MAX_OUTSTANDING = 8
);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic          fe_req;
  logic          fe_ready;
  logic          fe_pred_valid;
  logic          fe_pred;
  logic          be_upd_valid;
  logic          be_upd_taken;
  logic          be_upd_ready;
  logic          p_request;
  logic          p_result;
  logic          p_taken;
  logic          p_prediction;
  logic [OW-1:0] outstanding;
  logic          underflow;

  modport slave (
    input  fe_req, be_upd_valid, be_upd_taken, p_prediction,
    output fe_ready, fe_pred_valid, fe_pred, be_upd_ready,
           p_request, p_result, p_taken, outstanding, underflow
  );

  modport master (
    output fe_req, be_upd_valid, be_upd_taken, p_prediction,
    input  fe_ready, fe_pred_valid, fe_pred, be_upd_ready,
           p_request, p_result, p_taken, outstanding, underflow
  );
endinterface

// File: rtl/pred_sched.sv
// pred_sched: arbitrates the single-operation port of a 2-bit saturating
// branch predictor between fetch prediction requests and resolved-branch
// updates. Updates are buffered in a UQ_DEPTH-entry FIFO; fetch is forced to
// win after STARVE_LIMIT consecutive denied cycles; at most MAX_OUTSTANDING
// predictions may be unresolved.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pred_sched_if.slave (fetch, backend and predictor signals)
// Optional feature: define PRED_SCHED_BYPASS_EN to let an update arriving at
// an empty queue go straight to the predictor in the same cycle.
module pred_sched #(
  parameter int UQ_DEPTH        = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic          clk,
  input  logic          rst,
  pred_sched_if.slave   bus
);
  localparam int PW = $clog2(UQ_DEPTH);
  localparam int CW = $clog2(UQ_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [UQ_DEPTH-1:0] uq_q;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [OW-1:0]       out_q, out_d;
  logic                uf_q, uf_d;
  logic                rv_q, rp_q;
  logic                rdy_q;

  logic uq_empty, room, force_fe, upd_acc, byp;
  logic grant, issue, deq, enq, taken;

  assign uq_empty = (cnt_q == '0);
  assign room     = (out_q < OW'(MAX_OUTSTANDING));
  assign force_fe = bus.fe_req && (starve_q == SW'(STARVE_LIMIT)) && room;
  // rdy_q always equals !full, so it doubles as the full flag.
  assign upd_acc  = bus.be_upd_valid && rdy_q;

`ifdef PRED_SCHED_BYPASS_EN
  assign byp = uq_empty && bus.be_upd_valid && !force_fe;
`else
  assign byp = 1'b0;
`endif

  // Priority: forced fetch, queued/bypassed update, normal fetch, idle.
  always_comb begin
    grant = 1'b0;
    issue = 1'b0;
    deq   = 1'b0;
    taken = 1'b0;
    if (force_fe) begin
      grant = 1'b1;
    end else if (!uq_empty) begin
      issue = 1'b1;
      deq   = 1'b1;
      taken = uq_q[rd_ptr_q];
    end else if (byp) begin
      issue = 1'b1;
      taken = bus.be_upd_taken;
    end else if (bus.fe_req && room) begin
      grant = 1'b1;
    end
  end

  // A bypassed update is consumed directly and never occupies a slot.
  assign enq = upd_acc && !byp;

  always_comb begin
    rd_ptr_d = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(enq) - CW'(deq);

    starve_d = starve_q;
    if (grant || !bus.fe_req) begin
      starve_d = '0;
    end else if (starve_q < SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end

    // A grant and an accepted update in the same cycle cancel out.
    out_d = out_q;
    uf_d  = uf_q;
    if (grant && !upd_acc) begin
      out_d = out_q + OW'(1);
    end else if (upd_acc && !grant) begin
      if (out_q == '0) begin
        uf_d = 1'b1;
      end else begin
        out_d = out_q - OW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      out_q    <= '0;
      uf_q     <= 1'b0;
      rv_q     <= 1'b0;
      rp_q     <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      out_q    <= out_d;
      uf_q     <= uf_d;
      rv_q     <= grant;
      rp_q     <= grant && bus.p_prediction;
      rdy_q    <= (cnt_d != CW'(UQ_DEPTH));
    end
  end

  // Queue storage is data only; validity is carried by the pointers/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      uq_q[wr_ptr_q] <= bus.be_upd_taken;
    end
  end

  assign bus.fe_ready      = grant;
  assign bus.p_request     = grant;
  assign bus.p_result      = issue;
  assign bus.p_taken       = taken;
  assign bus.be_upd_ready  = rdy_q;
  assign bus.fe_pred_valid = rv_q;
  assign bus.fe_pred       = rp_q;
  assign bus.outstanding   = out_q;
  assign bus.underflow     = uf_q;
endmodule

// File: tb/tb_pred_sched.sv
// tb_pred_sched: bench for pred_sched. A behavioural 2-bit predictor is
// attached to the predictor port; a cycle model of the scheduler predicts
// every output, and expected fetch predictions go through a scoreboard queue.
module tb_pred_sched;
  localparam int UQD  = 4;
  localparam int MAXO = 8;
  localparam int SL   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pred_sched_if #(.MAX_OUTSTANDING(MAXO)) bus();

  pred_sched #(.UQ_DEPTH(UQD), .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Attached predictor: counter starts strongly taken, never reset.
  logic [1:0] pr_ctr = 2'b11;
  always_comb bus.p_prediction = pr_ctr[1];
  always @(posedge clk) begin
    if (bus.p_result) begin
      if (bus.p_taken && pr_ctr != 2'b11) pr_ctr <= pr_ctr + 2'b01;
      else if (!bus.p_taken && pr_ctr != 2'b00) pr_ctr <= pr_ctr - 2'b01;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Scheduler model state
  bit  m_uq[$];
  int  m_starve, m_out;
  bit  m_uf, m_rv;
  bit  [1:0] m_ctr = 2'b11;
  bit  exp_pred[$];

  task automatic model_reset();
    m_uq.delete();
    exp_pred.delete();
    m_starve = 0;
    m_out    = 0;
    m_uf     = 0;
    m_rv     = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.fe_req = 1'b0;
    bus.be_upd_valid = 1'b0;
    bus.be_upd_taken = 1'b0;
    #1;
    check_eq("rst_fe_pred_valid", 32'(bus.fe_pred_valid), 0);
    check_eq("rst_fe_pred", 32'(bus.fe_pred), 0);
    check_eq("rst_outstanding", 32'(bus.outstanding), 0);
    check_eq("rst_underflow", 32'(bus.underflow), 0);
    check_eq("rst_be_upd_ready", 32'(bus.be_upd_ready), 1);
    check_eq("rst_p_request", 32'(bus.p_request), 0);
    check_eq("rst_p_result", 32'(bus.p_result), 0);
    check_eq("rst_p_taken", 32'(bus.p_taken), 0);
    check_eq("rst_fe_ready", 32'(bus.fe_ready), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare every output with the model, advance it.
  task automatic step(input bit fe, input bit v, input bit t);
    bit room, full, f, g, iss, tk, byp, acc;
    @(negedge clk);
    bus.fe_req = fe;
    bus.be_upd_valid = v;
    bus.be_upd_taken = t;
    #1;
    room = (m_out < MAXO);
    full = (m_uq.size() == UQD);
    f = fe && (m_starve == SL) && room;
    g = 0; iss = 0; tk = 0; byp = 0;
    if (f) g = 1;
    else if (m_uq.size() > 0) begin iss = 1; tk = m_uq[0]; end
`ifdef PRED_SCHED_BYPASS_EN
    else if (v) begin iss = 1; tk = t; byp = 1; end
`endif
    else if (fe && room) g = 1;
    acc = v && !full;

    check_eq("fe_ready", 32'(bus.fe_ready), 32'(g));
    check_eq("p_request", 32'(bus.p_request), 32'(g));
    check_eq("p_result", 32'(bus.p_result), 32'(iss));
    check_eq("p_taken", 32'(bus.p_taken), 32'(tk));
    check_eq("be_upd_ready", 32'(bus.be_upd_ready), 32'(!full));
    check_eq("outstanding", 32'(bus.outstanding), 32'(m_out));
    check_eq("underflow", 32'(bus.underflow), 32'(m_uf));
    check_eq("fe_pred_valid", 32'(bus.fe_pred_valid), 32'(m_rv));
    if (bus.fe_pred_valid) begin
      if (exp_pred.size() == 0) check_eq("fe_pred_extra", 32'(bus.fe_pred_valid), 0);
      else check_eq("fe_pred", 32'(bus.fe_pred), 32'(exp_pred.pop_front()));
    end else begin
      check_eq("fe_pred_idle", 32'(bus.fe_pred), 0);
    end

    if (iss && !byp) void'(m_uq.pop_front());
    if (acc && !byp) m_uq.push_back(t);
    if (g) exp_pred.push_back(m_ctr[1]);
    if (iss) begin
      if (tk && m_ctr != 2'b11) m_ctr = m_ctr + 2'b01;
      else if (!tk && m_ctr != 2'b00) m_ctr = m_ctr - 2'b01;
    end
    m_rv = g;
    if (g || !fe) m_starve = 0;
    else if (m_starve < SL) m_starve++;
    if (g && !acc) m_out++;
    else if (acc && !g) begin
      if (m_out == 0) m_uf = 1;
      else m_out--;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fe_req = 1'b0;
    bus.be_upd_valid = 1'b0;
    bus.be_upd_taken = 1'b0;
    do_reset();

    // Single grant, prediction returned next cycle.
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);

    // Two more grants, two not-taken updates, then a fresh prediction.
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Continuous update stream against a held fetch request: starvation
    // forcing, queue filling and backpressure.
    for (int i = 0; i < 40; i++) step(1, 1, i[0]);
    for (int i = 0; i < 8; i++) step(0, 0, 0);

    // Fill outstanding to the limit, then release with one update.
    do_reset();
    for (int i = 0; i < 9; i++) step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Underflow is sticky.
    do_reset();
    step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);

    // Reset in the middle of traffic with entries queued and a return pending.
    for (int i = 0; i < 14; i++) step(1, 1, 0);
    step(1, 0, 0);
    do_reset();
    step(0, 0, 0);
    step(0, 1, 1);
    step(1, 0, 0);
    step(0, 0, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 137 == 136) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
